// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU control sequencer.
// State encoding is fixed because state_o exposes it for debug.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_RDMEM  = 3'd3,
    ST_OPLOAD = 3'd4,
    ST_EXEC   = 3'd5,
    ST_WBACK  = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  localparam logic [4:0] OP_LDI  = 5'b10000;
  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_BEQ  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11111;

  // Opcode bits that select the ALU class and, for ALU ops, the ALU mode.
  localparam int CLS_HI = 4;
  localparam int CLS_LO = 3;

  localparam logic [1:0] MODE_ARITH = 2'b00;
  localparam logic [1:0] MODE_LOGIC = 2'b01;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LDI,
    CLS_JMP,
    CLS_BEQ,
    CLS_HALT,
    CLS_NOP
  } op_class_e;

  function automatic op_class_e classify(input logic [4:0] op);
    op_class_e cls;
    if (op[CLS_HI:CLS_LO] == MODE_ARITH || op[CLS_HI:CLS_LO] == MODE_LOGIC) cls = CLS_ALU;
    else if (op == OP_LDI)  cls = CLS_LDI;
    else if (op == OP_JMP)  cls = CLS_JMP;
    else if (op == OP_BEQ)  cls = CLS_BEQ;
    else if (op == OP_HALT) cls = CLS_HALT;
    else                    cls = CLS_NOP;
    return cls;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave):
// decoded opcode and eq flag in, every datapath strobe/select and status out.
interface cpu_sequencer_if #(
  parameter int OPW   = 5,
  parameter int MODEW = 2,
  parameter int CNTW  = 16
);
  logic             en;
  logic [OPW-1:0]   opcode;
  logic             eq;
  logic             loadIR;
  logic             incPC;
  logic             loadPC;
  logic             loadA;
  logic             loadB;
  logic             loadC;
  logic             we_DM;
  logic             selA;
  logic             selB;
  logic [MODEW-1:0] mode;
  logic             halted;
  logic [2:0]       state_o;
  logic [CNTW-1:0]  retired;

  modport master (
    input  en, opcode, eq,
    output loadIR, incPC, loadPC, loadA, loadB, loadC, we_DM,
           selA, selB, mode, halted, state_o, retired
  );

  modport slave (
    output en, opcode, eq,
    input  loadIR, incPC, loadPC, loadA, loadB, loadC, we_DM,
           selA, selB, mode, halted, state_o, retired
  );
endinterface

// File: rtl/cpu_retire_counter.sv
// Retired-instruction counter: counts inc pulses while enabled, wraps naturally.
module cpu_retire_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            inc,
  output logic [CNTW-1:0] count
);

  logic [CNTW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && inc) count_d = count_q + CNTW'(1);
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/operand/execute/writeback control FSM for the 19-bit CPU.
// Outputs are Moore-decoded from the state and latched opcode; strobes are qualified by en.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW   = 5,
  parameter int MODEW = 2,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  cpu_sequencer_if.master bus
);

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  op_class_e        cls_in, cls_q;
  logic             retire;
  logic [CNTW-1:0]  retired_cnt;

  logic             load_ir_c, inc_pc_c, load_pc_c, load_a_c, load_b_c, load_c_c, we_dm_c;
  logic             sel_a_c, sel_b_c, halted_c;
  logic [MODEW-1:0] mode_c;

  assign cls_in = classify(bus.opcode);
  assign cls_q  = classify(op_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    retire    = 1'b0;
    load_ir_c = 1'b0;
    inc_pc_c  = 1'b0;
    load_pc_c = 1'b0;
    load_a_c  = 1'b0;
    load_b_c  = 1'b0;
    load_c_c  = 1'b0;
    we_dm_c   = 1'b0;
    sel_a_c   = 1'b0;
    sel_b_c   = 1'b0;
    halted_c  = 1'b0;
    mode_c    = MODEW'(MODE_ARITH);

    case (state_q)
      ST_IDLE: begin
        sel_b_c = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        load_ir_c = 1'b1;
        inc_pc_c  = 1'b1;
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        // IR was loaded at the end of FETCH, so the live opcode is valid here.
        op_d = bus.opcode;
        case (cls_in)
          CLS_ALU, CLS_BEQ: state_d = ST_RDMEM;
          CLS_LDI:          state_d = ST_EXEC;
          CLS_JMP: begin
            load_pc_c = 1'b1;
            retire    = 1'b1;
            state_d   = ST_FETCH;
          end
          CLS_HALT: begin
            retire  = 1'b1;
            state_d = ST_HALT;
          end
          default: begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_RDMEM: state_d = ST_OPLOAD;
      ST_OPLOAD: begin
        load_a_c = 1'b1;
        load_b_c = 1'b1;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_ALU: begin
            mode_c   = MODEW'(op_q[CLS_HI:CLS_LO]);
            load_c_c = 1'b1;
            state_d  = ST_WBACK;
          end
          CLS_LDI: begin
            load_c_c = 1'b1;
            sel_a_c  = 1'b1;
            state_d  = ST_WBACK;
          end
          CLS_BEQ: begin
            load_pc_c = bus.eq;
            retire    = 1'b1;
            state_d   = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_WBACK: begin
        we_dm_c = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: halted_c = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    // A stall freezes sequencing; HALT is already self-looping.
    if (!bus.en) begin
      state_d = state_q;
      op_d    = op_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  cpu_retire_counter #(.CNTW(CNTW)) u_retire (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .inc   (retire),
    .count (retired_cnt)
  );

  // Strobes need en; selects/status only need reset released, so they hold through a stall.
  logic strobe_ok, out_ok;
  assign out_ok    = ~rst;
  assign strobe_ok = out_ok & bus.en;

  assign bus.loadIR  = load_ir_c & strobe_ok;
  assign bus.incPC   = inc_pc_c  & strobe_ok;
  assign bus.loadPC  = load_pc_c & strobe_ok;
  assign bus.loadA   = load_a_c  & strobe_ok;
  assign bus.loadB   = load_b_c  & strobe_ok;
  assign bus.loadC   = load_c_c  & strobe_ok;
  assign bus.we_DM   = we_dm_c   & strobe_ok;
  assign bus.selA    = sel_a_c   & strobe_ok;
  assign bus.selB    = sel_b_c   & out_ok;
  assign bus.mode    = out_ok ? mode_c : '0;
  assign bus.halted  = halted_c  & out_ok;
  assign bus.state_o = out_ok ? 3'(state_q) : 3'(ST_IDLE);
  assign bus.retired = out_ok ? retired_cnt : '0;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-cycle vector table through a scoreboard
// queue, plus hand sequences for async reset mid-EXEC and counter wrap.
module tb_cpu_sequencer;

  typedef struct packed {
    logic        load_ir, inc_pc, load_pc, load_a, load_b, load_c, we_dm, sel_a, sel_b;
    logic [1:0]  mode;
    logic        halted;
    logic [2:0]  state;
    logic [15:0] retired;
  } obs_t;

  typedef struct {
    logic       en;
    logic [4:0] op;
    logic       eq;
    obs_t       exp;
  } vec_t;

  localparam logic [8:0] NO = 9'b000000000;
  localparam logic [8:0] IF = 9'b110000000;
  localparam logic [8:0] PC = 9'b001000000;
  localparam logic [8:0] AB = 9'b000110000;
  localparam logic [8:0] LC = 9'b000001000;
  localparam logic [8:0] WE = 9'b000000100;
  localparam logic [8:0] SA = 9'b000000010;
  localparam logic [8:0] SB = 9'b000000001;

  localparam logic [4:0] ALU0 = 5'b00001;
  localparam logic [4:0] ALU1 = 5'b01010;
  localparam logic [4:0] ALU2 = 5'b00011;
  localparam logic [4:0] LDI  = 5'b10000;
  localparam logic [4:0] JMP  = 5'b11000;
  localparam logic [4:0] BEQ  = 5'b11001;
  localparam logic [4:0] NOP  = 5'b10001;
  localparam logic [4:0] HLT  = 5'b11111;

  logic clk, rst, rst_w;
  int   checks, errors;
  vec_t tbl[$];
  obs_t sb[$];

  cpu_sequencer_if #(.OPW(5), .MODEW(2), .CNTW(16)) bus ();
  cpu_sequencer_if #(.OPW(5), .MODEW(2), .CNTW(4))  bus_w ();

  cpu_sequencer #(.OPW(5), .MODEW(2), .CNTW(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cpu_sequencer #(.OPW(5), .MODEW(2), .CNTW(4)) u_dut_w (
    .clk (clk),
    .rst (rst_w),
    .bus (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.load_ir = bus.loadIR;
    o.inc_pc  = bus.incPC;
    o.load_pc = bus.loadPC;
    o.load_a  = bus.loadA;
    o.load_b  = bus.loadB;
    o.load_c  = bus.loadC;
    o.we_dm   = bus.we_DM;
    o.sel_a   = bus.selA;
    o.sel_b   = bus.selB;
    o.mode    = bus.mode;
    o.halted  = bus.halted;
    o.state   = bus.state_o;
    o.retired = bus.retired;
    return o;
  endfunction

  function automatic obs_t mko(input logic [8:0] stb, input logic [1:0] mode,
                               input logic halted, input logic [2:0] st, input logic [15:0] ret);
    obs_t o;
    {o.load_ir, o.inc_pc, o.load_pc, o.load_a, o.load_b, o.load_c, o.we_dm, o.sel_a, o.sel_b} = stb;
    o.mode    = mode;
    o.halted  = halted;
    o.state   = st;
    o.retired = ret;
    return o;
  endfunction

  function automatic vec_t mk(input logic en, input logic [4:0] op, input logic eq,
                              input logic [8:0] stb, input logic [1:0] mode,
                              input logic halted, input logic [2:0] st, input logic [15:0] ret);
    vec_t v;
    v.en  = en;
    v.op  = op;
    v.eq  = eq;
    v.exp = mko(stb, mode, halted, st, ret);
    return v;
  endfunction

  // Drive one cycle's inputs after the edge, queue its expectation, compare at negedge.
  task automatic apply(input vec_t v, input string name);
    obs_t act, exp;
    @(posedge clk);
    #1;
    bus.en     = v.en;
    bus.opcode = v.op;
    bus.eq     = v.eq;
    sb.push_back(v.exp);
    @(negedge clk);
    act = sample();
    exp = sb.pop_front();
    check(name, 64'(act), 64'(exp));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    rst_w  = 1'b1;
    bus.en = 1'b1;
    bus.opcode = ALU0;
    bus.eq = 1'b0;
    bus_w.en = 1'b0;
    bus_w.opcode = NOP;
    bus_w.eq = 1'b0;

    // Reset state with en high: nothing may leak out while rst is asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'(sample()), 64'(mko(NO, 2'b00, 1'b0, 3'd0, 16'd0)));
    bus.en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // ALU arithmetic: 6 cycles, loadA/B in cycle 4, loadC mode 00 in 5, we_DM in 6.
    tbl.push_back(mk(1, ALU0, 0, SB,    2'b00, 0, 3'd0, 16'd0));
    tbl.push_back(mk(1, ALU0, 0, IF,    2'b00, 0, 3'd1, 16'd0));
    tbl.push_back(mk(1, ALU0, 0, NO,    2'b00, 0, 3'd2, 16'd0));
    tbl.push_back(mk(1, ALU0, 0, NO,    2'b00, 0, 3'd3, 16'd0));
    tbl.push_back(mk(1, ALU0, 0, AB,    2'b00, 0, 3'd4, 16'd0));
    tbl.push_back(mk(1, ALU0, 0, LC,    2'b00, 0, 3'd5, 16'd0));
    tbl.push_back(mk(1, ALU0, 0, WE,    2'b00, 0, 3'd6, 16'd0));
    // LDI: 4 cycles, loadC with selA=1.
    tbl.push_back(mk(1, LDI,  0, IF,    2'b00, 0, 3'd1, 16'd1));
    tbl.push_back(mk(1, LDI,  0, NO,    2'b00, 0, 3'd2, 16'd1));
    tbl.push_back(mk(1, LDI,  0, LC|SA, 2'b00, 0, 3'd5, 16'd1));
    tbl.push_back(mk(1, LDI,  0, WE,    2'b00, 0, 3'd6, 16'd1));
    // ALU logic class: mode 01 in EXEC.
    tbl.push_back(mk(1, ALU1, 0, IF,    2'b00, 0, 3'd1, 16'd2));
    tbl.push_back(mk(1, ALU1, 0, NO,    2'b00, 0, 3'd2, 16'd2));
    tbl.push_back(mk(1, ALU1, 0, NO,    2'b00, 0, 3'd3, 16'd2));
    tbl.push_back(mk(1, ALU1, 0, AB,    2'b00, 0, 3'd4, 16'd2));
    tbl.push_back(mk(1, ALU1, 0, LC,    2'b01, 0, 3'd5, 16'd2));
    tbl.push_back(mk(1, ALU1, 0, WE,    2'b00, 0, 3'd6, 16'd2));
    // BEQ taken: loadPC in EXEC, 5 cycles.
    tbl.push_back(mk(1, BEQ,  1, IF,    2'b00, 0, 3'd1, 16'd3));
    tbl.push_back(mk(1, BEQ,  1, NO,    2'b00, 0, 3'd2, 16'd3));
    tbl.push_back(mk(1, BEQ,  1, NO,    2'b00, 0, 3'd3, 16'd3));
    tbl.push_back(mk(1, BEQ,  1, AB,    2'b00, 0, 3'd4, 16'd3));
    tbl.push_back(mk(1, BEQ,  1, PC,    2'b00, 0, 3'd5, 16'd3));
    // BEQ not taken: no loadPC, still retires.
    tbl.push_back(mk(1, BEQ,  0, IF,    2'b00, 0, 3'd1, 16'd4));
    tbl.push_back(mk(1, BEQ,  0, NO,    2'b00, 0, 3'd2, 16'd4));
    tbl.push_back(mk(1, BEQ,  0, NO,    2'b00, 0, 3'd3, 16'd4));
    tbl.push_back(mk(1, BEQ,  0, AB,    2'b00, 0, 3'd4, 16'd4));
    tbl.push_back(mk(1, BEQ,  0, NO,    2'b00, 0, 3'd5, 16'd4));
    // ALU with a 3-cycle stall in OPLOAD: loadA/B issued once on resume.
    tbl.push_back(mk(1, ALU2, 0, IF,    2'b00, 0, 3'd1, 16'd5));
    tbl.push_back(mk(1, ALU2, 0, NO,    2'b00, 0, 3'd2, 16'd5));
    tbl.push_back(mk(1, ALU2, 0, NO,    2'b00, 0, 3'd3, 16'd5));
    tbl.push_back(mk(0, ALU2, 0, NO,    2'b00, 0, 3'd4, 16'd5));
    tbl.push_back(mk(0, ALU2, 0, NO,    2'b00, 0, 3'd4, 16'd5));
    tbl.push_back(mk(0, ALU2, 0, NO,    2'b00, 0, 3'd4, 16'd5));
    tbl.push_back(mk(1, ALU2, 0, AB,    2'b00, 0, 3'd4, 16'd5));
    tbl.push_back(mk(1, ALU2, 0, LC,    2'b00, 0, 3'd5, 16'd5));
    tbl.push_back(mk(1, ALU2, 0, WE,    2'b00, 0, 3'd6, 16'd5));
    // JMP: loadPC in DECODE, FETCH next.
    tbl.push_back(mk(1, JMP,  0, IF,    2'b00, 0, 3'd1, 16'd6));
    tbl.push_back(mk(1, JMP,  0, PC,    2'b00, 0, 3'd2, 16'd6));
    // NOP: 2 cycles, no strobes in DECODE.
    tbl.push_back(mk(1, NOP,  0, IF,    2'b00, 0, 3'd1, 16'd7));
    tbl.push_back(mk(1, NOP,  0, NO,    2'b00, 0, 3'd2, 16'd7));
    // HALT: retires once, then terminal with en toggling.
    tbl.push_back(mk(1, HLT,  0, IF,    2'b00, 0, 3'd1, 16'd8));
    tbl.push_back(mk(1, HLT,  0, NO,    2'b00, 0, 3'd2, 16'd8));
    for (int i = 0; i < 21; i++)
      tbl.push_back(mk(1'($urandom_range(0, 1)), ALU0, 1, NO, 2'b00, 1, 3'd7, 16'd9));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    // Async reset in EXEC of an ALU op: immediate zero outputs, no we_DM afterwards.
    @(posedge clk);
    #1 rst = 1'b1;
    bus.en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    apply(mk(1, JMP,  0, SB, 2'b00, 0, 3'd0, 16'd0), "rx_idle");
    apply(mk(1, JMP,  0, IF, 2'b00, 0, 3'd1, 16'd0), "rx_fetch0");
    apply(mk(1, JMP,  0, PC, 2'b00, 0, 3'd2, 16'd0), "rx_jmp");
    apply(mk(1, ALU1, 0, IF, 2'b00, 0, 3'd1, 16'd1), "rx_fetch1");
    apply(mk(1, ALU1, 0, NO, 2'b00, 0, 3'd2, 16'd1), "rx_decode");
    apply(mk(1, ALU1, 0, NO, 2'b00, 0, 3'd3, 16'd1), "rx_rdmem");
    apply(mk(1, ALU1, 0, AB, 2'b00, 0, 3'd4, 16'd1), "rx_opload");
    apply(mk(1, ALU1, 0, LC, 2'b01, 0, 3'd5, 16'd1), "rx_exec");
    rst = 1'b1;
    #1;
    check("rx_async_zero", 64'(sample()), 64'(mko(NO, 2'b00, 0, 3'd0, 16'd0)));
    @(negedge clk);
    check("rx_rst_hold", 64'(sample()), 64'(mko(NO, 2'b00, 0, 3'd0, 16'd0)));
    @(posedge clk);
    #1 rst = 1'b0;
    bus.en = 1'b0;
    @(negedge clk);
    check("rx_after_release", 64'(sample()), 64'(mko(SB, 2'b00, 0, 3'd0, 16'd0)));

    // Counter wrap on a 4-bit instance running back-to-back NOPs.
    @(posedge clk);
    #1 rst_w = 1'b0;
    bus_w.en = 1'b1;
    for (int c = 0; c <= 35; c++) begin
      int exp_ret;
      @(negedge clk);
      exp_ret = (c == 0) ? 0 : ((c - 1) / 2) % 16;
      check($sformatf("wrap_c%0d", c), 64'(bus_w.retired), 64'(exp_ret));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 19-bit CPU datapath: instruction memory, instruction register, PC, regA/regB/regC, data memory, muxA/muxB and ALU.
- Consumes the decoded 5-bit opcode and the ALU eq flag.
- Produces every datapath strobe and select (loadIR, incPC, loadPC, loadA, loadB, loadC, we_DM, selA, selB, mode) plus run status.
- Replaces the free-running controller with an explicit fetch/decode/operand/execute/writeback schedule and a HALT state.

Parameters:
- OPW, 5, opcode width (instruction bits [18:14]).
- MODEW, 2, ALU mode width.
- CNTW, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low stalls the FSM.
- opcode  in  OPW  opcode from the instruction register.
- eq  in  1  ALU equality flag.
- loadIR  out  1  instruction register load.
- incPC  out  1  PC increment.
- loadPC  out  1  PC load from IR address field.
- loadA  out  1  regA load from data memory [15:0].
- loadB  out  1  regB load from data memory [31:16].
- loadC  out  1  regC load from muxA.
- we_DM  out  1  data memory write of regC at IR address.
- selA  out  1  muxA select: 0 = ALU result, 1 = immediate.
- selB  out  1  muxB select: 0 = PC, 1 = external immediate address (program load).
- mode  out  MODEW  ALU mode.
- halted  out  1  high while in HALT.
- state_o  out  3  current state encoding, for debug.
- retired  out  CNTW  count of completed instructions.

Behaviour:
- Reset, asynchronous: state=IDLE, retired=0. All strobes, selA, selB, mode and halted are 0.
- Encoding: IDLE=0, FETCH=1, DECODE=2, RDMEM=3, OPLOAD=4, EXEC=5, WBACK=6, HALT=7.
- Outputs are Moore, decoded from the state register plus the latched opcode class. Strobes are single-cycle pulses.
- en=0: state, counter and latched opcode hold. All strobes forced 0; selB, mode and halted keep their values. Resumption continues exactly where it stopped.
- IDLE -> FETCH on the first en=1 cycle; selB=1 while in IDLE.
- FETCH: loadIR=1, incPC=1, selB=0 -> DECODE. IM read is synchronous, so the addressed word is valid in FETCH.
- DECODE: latch opcode into op_q.
  - op_q=00xxx (ALU mode 00), 01xxx (ALU mode 01), 11001 (BEQ) -> RDMEM.
  - 10000 (LDI) -> EXEC.
  - 11000 (JMP): loadPC=1 in DECODE, retire -> FETCH.
  - 11111 (HALT) -> HALT.
  - All other codes: NOP, retire -> FETCH.
- RDMEM: DM address presented; no strobes (one-cycle synchronous read latency) -> OPLOAD.
- OPLOAD: loadA=1, loadB=1 -> EXEC.
- EXEC: mode = op_q[4:3] for ALU classes, 00 for BEQ.
  - ALU class: loadC=1, selA=0 -> WBACK.
  - LDI: loadC=1, selA=1 -> WBACK.
  - BEQ: if eq=1 then loadPC=1; retire -> FETCH.
- WBACK: we_DM=1, retire -> FETCH.
- HALT: halted=1; terminal until rst; en has no effect.
- retired increments by 1 on each retire event and wraps modulo 2^CNTW. HALT itself counts as retired once, on DECODE->HALT.
- Mutual exclusion: loadPC and incPC are never high in the same cycle. we_DM is never high in the same cycle as loadA/loadB.
- Reset mid-instruction: abort immediately to IDLE; no partial strobe is emitted after rst rises.
- Cycles per instruction:
  - ALU: 6 (FETCH, DECODE, RDMEM, OPLOAD, EXEC, WBACK).
  - LDI: 4.
  - BEQ: 5.
  - JMP and NOP: 2.

Decomposition:
- Shared package cpu_pkg:
  - state localparams.
  - opcode constants OP_LDI=5'b10000, OP_JMP=5'b11000, OP_BEQ=5'b11001, OP_HALT=5'b11111.
  - class field positions [4:3].
  - ALU mode constants MODE_ARITH=2'b00, MODE_LOGIC=2'b01.
- One sub-module, cpu_retire_counter: CNTW-bit counter with async reset, inc input and enable gating.

Test Plan:
- Reset then en=1, opcode=5'b00001 -> FETCH at cycle 1. loadA/loadB pulse in cycle 4, loadC with mode=00 in cycle 5, we_DM in cycle 6, retired=1.
- opcode=5'b10000 (LDI) -> EXEC asserts loadC=1 with selA=1; WBACK asserts we_DM=1; 4 cycles total; retired increments.
- BEQ with eq=1 -> loadPC pulses in EXEC. BEQ with eq=0 -> loadPC stays 0. Both take 5 cycles, and incPC fires only in FETCH.
- JMP -> loadPC in DECODE, next cycle is FETCH. Then HALT -> halted=1, state_o=7, no further strobes over 20 cycles with en toggling.
- en dropped during OPLOAD for 3 cycles -> all strobes 0 and state held. On resume the loadA/loadB pulse is issued exactly once.
- rst asserted during EXEC of an ALU op -> outputs 0 asynchronously, retired=0, no we_DM. Also preload retired=16'hFFFF via repeated NOPs -> wraps to 0.
